// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the nrdiv launcher and its result checkers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    localparam int OPW = 16;  // operand / remainder width
    localparam int QW  = 8;   // quotient width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_DBZ = 2'b01;
    localparam logic [1:0] ERR_OVF = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

endpackage

// File: rtl/div_launch_chk.sv
// div_launch_chk: combinational divide-by-zero / fractional-overflow screen of an operand pair.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when the result is used.
module div_launch_chk
    import div_pkg::*;
(
    input  logic [OPW-1:0] x,
    input  logic [OPW-1:0] y,
    output logic           dbz,
    output logic           ovf
);

    // Zero divisor dominates; overflow only reported for a non-zero divisor.
    always_comb begin
        dbz = (y == '0);
        ovf = !dbz && (x >= y);
    end

endmodule

// File: rtl/div_launch.sv
// div_launch: screens operand pairs, issues a start pulse to nrdiv, captures q/r/err on done.
// Latency: error result 1 cycle after acceptance; divided result 11 cycles (START + 9 divider + capture).
// Backpressure: in_ready low while an op is in flight; result held in RESP until out_ready.
// Optional: DIV_LAUNCH_STATS_EN adds saturating stat_ops / stat_errs counters.
module div_launch
    import div_pkg::*;
#(
    parameter int DONE_TIMEOUT = 16,
    parameter int TW           = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_x,
    input  logic [OPW-1:0] in_y,
    output logic [OPW-1:0] div_x,
    output logic [OPW-1:0] div_y,
    output logic           div_start,
    input  logic [QW-1:0]  div_z,
    input  logic [OPW-1:0] div_r,
    input  logic           div_done,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [QW-1:0]  out_q,
    output logic [OPW-1:0] out_r,
    output logic [1:0]     out_err
`ifdef DIV_LAUNCH_STATS_EN
    ,
    output logic [15:0]    stat_ops,
    output logic [15:0]    stat_errs
`endif
);

    localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT);

    state_t         state_q,     state_d;
    logic           in_ready_q,  in_ready_d;
    logic           div_start_q, div_start_d;
    logic           out_valid_q, out_valid_d;
    logic [OPW-1:0] div_x_q,     div_x_d;
    logic [OPW-1:0] div_y_q,     div_y_d;
    logic [QW-1:0]  quo_q,       quo_d;
    logic [OPW-1:0] rem_q,       rem_d;
    logic [1:0]     err_q,       err_d;
    logic [TW-1:0]  cnt_q,       cnt_d;
    logic [TW-1:0]  cnt_inc;

    logic chk_dbz;
    logic chk_ovf;

    div_launch_chk u_chk (
        .x   (in_x),
        .y   (in_y),
        .dbz (chk_dbz),
        .ovf (chk_ovf)
    );

    // Next-state and capture logic; control outputs are registered from the next state.
    always_comb begin
        state_d = state_q;
        div_x_d = div_x_q;
        div_y_d = div_y_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + TW'(1);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    div_x_d = in_x;
                    div_y_d = in_y;
                    if (chk_dbz) begin
                        quo_d   = '1;
                        rem_d   = in_x;
                        err_d   = ERR_DBZ;
                        state_d = RESP;
                    end else if (chk_ovf) begin
                        quo_d   = '1;
                        rem_d   = '0;
                        err_d   = ERR_OVF;
                        state_d = RESP;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A done on the terminal-count cycle still counts as a good result.
                if (div_done) begin
                    quo_d   = div_z;
                    rem_d   = div_r;
                    err_d   = ERR_OK;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TMO_LAST) begin
                        quo_d   = '0;
                        rem_d   = '0;
                        err_d   = ERR_TMO;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        div_start_d = (state_d == START);
        out_valid_d = (state_d == RESP);
    end

    // State and capture registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            div_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            div_x_q     <= '0;
            div_y_q     <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            err_q       <= ERR_OK;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            div_start_q <= div_start_d;
            out_valid_q <= out_valid_d;
            div_x_q     <= div_x_d;
            div_y_q     <= div_y_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign div_start = div_start_q;
    assign div_x     = div_x_q;
    assign div_y     = div_y_q;
    assign out_valid = out_valid_q;
    assign out_q     = quo_q;
    assign out_r     = rem_q;
    assign out_err   = err_q;

`ifdef DIV_LAUNCH_STATS_EN
    logic [15:0] ops_q,  ops_d;
    logic [15:0] errs_q, errs_d;
    logic        resp_hs;

    // Count completed result handshakes, saturating at all-ones.
    always_comb begin
        resp_hs = (state_q == RESP) && out_ready;
        ops_d   = ops_q;
        errs_d  = errs_q;
        if (resp_hs) begin
            if (ops_q != 16'hFFFF) begin
                ops_d = ops_q + 16'd1;
            end
            if ((err_q != ERR_OK) && (errs_q != 16'hFFFF)) begin
                errs_d = errs_q + 16'd1;
            end
        end
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ops_q  <= '0;
            errs_q <= '0;
        end else begin
            ops_q  <= ops_d;
            errs_q <= errs_d;
        end
    end

    assign stat_ops  = ops_q;
    assign stat_errs = errs_q;
`endif

endmodule

// File: doc/div_launch.md
Name: div_launch

Overview:
- Upstream sequencer for the 16/16 -> 8-bit-quotient non-restoring divider (the `nrdiv` block).
- Accepts operand pairs over a valid/ready handshake and screens them for divide-by-zero and fractional overflow. Issues a one-cycle start to the divider and captures quotient/remainder on its done pulse.
- Returns results with error flags over a second valid/ready handshake.
- Sits between the operand source and the divider; owns all divider control.

Parameters:
- DONE_TIMEOUT, 16, max cycles in WAIT before a timeout error is declared (must be > 9).
- TW, 5, timeout counter width; must satisfy 2^TW > DONE_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  launcher can accept operands
- in_x  in  16  dividend (unsigned; fractional, must be < divisor)
- in_y  in  16  divisor (unsigned, < 2^15)
- div_x  out  16  to divider X
- div_y  out  16  to divider Y
- div_start  out  1  to divider start, one-cycle pulse
- div_z  in  8  divider quotient
- div_r  in  16  divider remainder
- div_done  in  1  divider done pulse
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_q  out  8  quotient
- out_r  out  16  remainder
- out_err  out  2  00 ok, 01 divide-by-zero, 10 overflow, 11 timeout

Behaviour:
- Reset values: state=IDLE, in_ready=1, div_start=0, div_x=div_y=0, out_valid=0, out_q=0, out_r=0, out_err=00, timeout counter=0.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - in_ready=1. On in_valid, register in_x/in_y into div_x/div_y.
  - If in_y==0: out_q=8'hFF, out_r=in_x, err=01, go RESP.
  - Else if in_x>=in_y: out_q=8'hFF, out_r=0, err=10, go RESP.
  - Else go START.
  - Divide-by-zero has priority over overflow.
- START: div_start=1 for exactly this cycle; timeout counter cleared; go WAIT.
- WAIT:
  - div_start=0. On div_done: out_q<=div_z, out_r<=div_r, err=00, go RESP.
  - Otherwise increment counter. When counter reaches DONE_TIMEOUT: out_q=0, out_r=0, err=11, go RESP.
- RESP: out_valid=1; out_q/out_r/out_err held stable. When out_ready is high, out_valid drops next cycle; go IDLE.
- Latency, in_valid accepted to out_valid:
  - Error path: 1 cycle.
  - Normal path: 1 (START) + divider latency + 1. The divider asserts done 9 cycles after the start edge, so out_valid rises 11 cycles after acceptance.
- Handshake:
  - in_ready is deasserted in START/WAIT/RESP, so only one operation is in flight.
  - div_x/div_y are held constant from acceptance until the next acceptance.
- div_done is ignored in IDLE, START and RESP. The divider's free-running counter produces stray done pulses every 64 cycles when idle.
- div_done coincident with the timeout terminal count: done wins, err=00.
- Reset mid-operation: returns to IDLE on the next edge with div_start=0 and out_valid=0. Any later divider done is ignored; the divider needs no reset because the next start reinitialises it.
- in_valid while in_ready=0 has no effect; operands are not sampled.
- out_ready low in RESP: hold indefinitely, no data loss.

Optional Feature:
- Macro DIV_LAUNCH_STATS_EN.
- When defined, adds outputs stat_ops (16-bit count of completed RESP handshakes) and stat_errs (16-bit count of those with err!=00).
  - Both counters saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package div_pkg holds:
  - state enum (IDLE, START, WAIT, RESP);
  - error code constants ERR_OK=2'b00, ERR_DBZ=2'b01, ERR_OVF=2'b10, ERR_TMO=2'b11;
  - operand and quotient width constants (16, 8).
- One natural sub-module: div_launch_chk, the combinational zero/overflow screen, reused by a future downstream result checker.
- FSM and capture registers stay in div_launch.

Test Plan:
- x=16'h0100, y=16'h0400, with divider attached:
  - div_start pulses once, one cycle after acceptance.
  - out_q=8'h40 (0.25*256), out_r consistent with the divider, err=00.
  - out_valid 11 cycles after acceptance.
- y=0, x=16'h1234 -> out_valid next cycle, q=FF, r=1234, err=01; div_start never asserted.
- x=y=16'h0200 -> q=FF, r=0, err=10, no div_start.
- Divider model that never pulses done -> err=11 after DONE_TIMEOUT cycles in WAIT, q=r=0; stray done injected while IDLE produces no output.
- out_ready held low 20 cycles in RESP -> outputs stable, in_ready=0; accept on cycle 21, then in_ready=1 next cycle.
- Assert reset during WAIT:
  - next edge: IDLE, out_valid=0;
  - divider done arriving afterward is ignored;
  - a new request completes normally.
